// File: rtl/vga_pixel_sink.sv
// PIO-fed grayscale pixel sink: toggle-detected ingress into a FWFT FIFO, drained by a
// free-running VGA timing generator with SOF-based frame resynchronisation.
module vga_pixel_sink #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned FIFO_AW  = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] in_port,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic [15:0] status
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DEPTH   = 1 << FIFO_AW;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned LW      = FIFO_AW + 1;

   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
   localparam logic [LW-1:0] FULL_C   = LW'(DEPTH);

   // in_q = {toggle, sof, pixel}; reserved PIO bits are not stored
   logic [9:0]         in_q;
   logic               tog_q;
   logic               unused_rsvd;

   logic [8:0]         mem [DEPTH];
   logic [LW-1:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [LW-1:0]      level, level_d;
   logic [8:0]         head;
   logic               empty, full, full_d;

   logic [HW-1:0]      h_cnt_q;
   logic [VW-1:0]      v_cnt_q;
   logic               active, origin, hs_n, vs_n;

   logic               push_req, push_ok, pop, frame_sync;
   logic               ovf_q, und_q, ovf_d, und_d;
   logic [31:0]        level_ext;
   logic [9:0]         level_sat;

   logic [7:0]         pix_q;
   logic               hs_q, vs_q, blank_n_q;
   logic [15:0]        status_q;

   assign unused_rsvd = ^in_port[21:8];

   assign level = wr_ptr_q - rd_ptr_q;
   assign empty = (level == '0);
   assign full  = (level == FULL_C);
   assign head  = mem[rd_ptr_q[FIFO_AW-1:0]];

   assign active = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
   assign origin = (h_cnt_q == '0) && (v_cnt_q == '0);
   assign hs_n   = !((h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C));
   assign vs_n   = !((v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C));

   always_comb begin
      push_req   = (in_q[9] != tog_q);
      // An SOF head is only released at the frame origin; elsewhere it stalls output.
      pop        = active && !empty && (!head[8] || origin);
      frame_sync = pop && head[8];
      push_ok    = push_req && (!full || pop);

      wr_ptr_d   = wr_ptr_q + {{FIFO_AW{1'b0}}, push_ok};
      rd_ptr_d   = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
      level_d    = wr_ptr_d - rd_ptr_d;
      full_d     = (level_d == FULL_C);

      ovf_d      = ovf_q | (push_req && full && !pop);
      und_d      = und_q | (active && empty);
      if (frame_sync) begin
         ovf_d = 1'b0;
         und_d = 1'b0;
      end

      level_ext  = 32'(level_d);
      level_sat  = (level_ext > 32'd1023) ? 10'h3FF : level_ext[9:0];
   end

   always_ff @(posedge clk) begin
      if (push_ok && !reset) begin
         mem[wr_ptr_q[FIFO_AW-1:0]] <= in_q[8:0];
      end
   end

   always_ff @(posedge clk) begin
      in_q <= {in_port[23:22], in_port[7:0]};
      if (reset) begin
         // Track the live toggle so the first post-reset cycle sees no edge.
         tog_q     <= in_port[23];
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         ovf_q     <= 1'b0;
         und_q     <= 1'b0;
         pix_q     <= 8'h00;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         status_q  <= 16'h0000;
      end else begin
         if (push_req) begin
            tog_q <= in_q[9];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         und_q    <= und_d;

         if (h_cnt_q == H_LAST_C) begin
            h_cnt_q <= '0;
            v_cnt_q <= (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + VW'(1);
         end else begin
            h_cnt_q <= h_cnt_q + HW'(1);
         end

         pix_q     <= pop ? head[7:0] : 8'h00;
         hs_q      <= hs_n;
         vs_q      <= vs_n;
         blank_n_q <= active;
         status_q  <= {ovf_d, und_d, full_d, 3'b000, level_sat};
      end
   end

   assign vga_r       = pix_q;
   assign vga_g       = pix_q;
   assign vga_b       = pix_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;
   assign status      = status_q;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Directed bench for vga_pixel_sink on a shrunken raster (15x8 total, 8x4 active, 8-deep FIFO).
module tb_vga_pixel_sink;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
   localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;

   logic        clk, reset;
   logic [23:0] in_port;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n;
   logic [15:0] status;

   int n_cmp = 0;
   int n_bad = 0;
   int mh, mv;
   logic tog;

   typedef struct {
      int         h;
      int         v;
      logic [23:0] rgb;
      logic       hs;
      logic       vs;
      logic       bl;
   } tvec_t;

   tvec_t tv [12];

   vga_pixel_sink #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .FIFO_AW(3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_port    (in_port),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .vga_hs     (vga_hs),
      .vga_vs     (vga_vs),
      .vga_blank_n(vga_blank_n),
      .status     (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference raster position of the cycle that follows each edge.
   always @(posedge clk) begin
      if (reset) begin
         mh <= 0;
         mv <= 0;
      end else if (mh == HT - 1) begin
         mh <= 0;
         mv <= (mv == VT - 1) ? 0 : mv + 1;
      end else begin
         mh <= mh + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_pos(input int h, input int v);
      bit found = 0;
      for (int n = 0; n < 1000; n++) begin
         tick();
         if (mh == h && mv == v) begin
            found = 1;
            break;
         end
      end
      if (!found) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_pos(%0d,%0d): timed out, expected to reach it", h, v);
      end
   endtask

   task automatic push(input logic sof, input logic [7:0] pix);
      tog     = ~tog;
      in_port = {tog, sof, 14'h1555, pix};
   endtask

   function automatic logic [23:0] rgb();
      return {vga_r, vga_g, vga_b};
   endfunction

   initial begin
      int hs_lo, vs_lo, bl_hi, nz;
      bit found;

      tv[0]  = '{0,  0, 24'h0, 1'b1, 1'b1, 1'b1};
      tv[1]  = '{7,  3, 24'h0, 1'b1, 1'b1, 1'b1};
      tv[2]  = '{8,  3, 24'h0, 1'b1, 1'b1, 1'b0};
      tv[3]  = '{9,  0, 24'h0, 1'b1, 1'b1, 1'b0};
      tv[4]  = '{10, 0, 24'h0, 1'b0, 1'b1, 1'b0};
      tv[5]  = '{12, 2, 24'h0, 1'b0, 1'b1, 1'b0};
      tv[6]  = '{13, 2, 24'h0, 1'b1, 1'b1, 1'b0};
      tv[7]  = '{14, 7, 24'h0, 1'b1, 1'b1, 1'b0};
      tv[8]  = '{0,  4, 24'h0, 1'b1, 1'b1, 1'b0};
      tv[9]  = '{0,  5, 24'h0, 1'b1, 1'b0, 1'b0};
      tv[10] = '{11, 6, 24'h0, 1'b0, 1'b0, 1'b0};
      tv[11] = '{3,  7, 24'h0, 1'b1, 1'b1, 1'b0};

      // Reset with toggle already high: no spurious push afterwards.
      tog     = 1'b1;
      in_port = 24'h800000;
      reset   = 1'b1;
      repeat (3) tick();
      check("rst_rgb", 32'(rgb()), 32'h0);
      check("rst_hs", 32'(vga_hs), 32'h1);
      check("rst_vs", 32'(vga_vs), 32'h1);
      check("rst_blank_n", 32'(vga_blank_n), 32'h0);
      check("rst_status", 32'(status), 32'h0);
      reset = 1'b0;
      repeat (3) tick();
      check("rst_no_push_level", 32'(status[9:0]), 32'h0);

      // Output alignment: outputs one cycle after the raster position.
      for (int i = 0; i < 12; i++) begin
         wait_pos(tv[i].h, tv[i].v);
         tick();
         check($sformatf("timing(%0d,%0d)", tv[i].h, tv[i].v),
               {5'h0, rgb(), vga_hs, vga_vs, vga_blank_n},
               {5'h0, tv[i].rgb, tv[i].hs, tv[i].vs, tv[i].bl});
      end

      // Two whole frames with an empty FIFO.
      hs_lo = 0; vs_lo = 0; bl_hi = 0;
      for (int i = 0; i < 2 * HT * VT; i++) begin
         tick();
         if (!vga_hs) hs_lo++;
         if (!vga_vs) vs_lo++;
         if (vga_blank_n) bl_hi++;
      end
      check("frame_hs_low", 32'(hs_lo), 32'(2 * VT * HS));
      check("frame_vs_low", 32'(vs_lo), 32'(2 * VS * HT));
      check("frame_blank_hi", 32'(bl_hi), 32'(2 * HA * VA));
      check("frame_underrun", 32'(status[14]), 32'h1);

      // Overflow: 9 back-to-back pushes into the 8-deep FIFO during vertical blanking.
      wait_pos(0, 4);
      for (int i = 0; i < 9; i++) begin
         push(1'b0, 8'h10 + 8'(i));
         tick();
      end
      repeat (2) tick();
      check("ovf_full", 32'(status[13]), 32'h1);
      check("ovf_level", 32'(status[9:0]), 32'd8);
      check("ovf_sticky", 32'(status[15]), 32'h1);
      wait_pos(0, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("ovf_drain%0d", i), 32'(rgb()), 32'({3{8'h10 + 8'(i)}}));
      end
      wait_pos(0, 1);
      tick();
      check("ovf_ninth_absent", 32'(rgb()), 32'h0);
      check("ovf_drained_level", 32'(status[9:0]), 32'h0);

      // Resync: SOF pixel pushed mid-frame is held until the frame origin.
      push(1'b1, 8'h55);
      nz = 0;
      found = 0;
      for (int n = 0; n < 1000; n++) begin
         tick();
         if (mh == 0 && mv == 0) begin
            found = 1;
            break;
         end
         if (rgb() != 24'h0) nz++;
      end
      check("resync_reached_origin", 32'(found), 32'h1);
      check("resync_held_black", 32'(nz), 32'h0);
      check("resync_held_level", 32'(status[9:0]), 32'h1);
      check("resync_stickies_before", 32'(status[15:14]), 32'h3);
      tick();
      check("resync_rgb", 32'(rgb()), 32'h555555);
      check("resync_status", 32'(status), 32'h0);

      // Simultaneous push and pop at level 3.
      wait_pos(0, 5);
      for (int i = 0; i < 3; i++) begin
         push(1'b0, 8'h21 + 8'(i));
         tick();
      end
      wait_pos(14, 7);
      check("simul_pre_level", 32'(status[9:0]), 32'd3);
      for (int k = 0; k < 8; k++) begin
         push(1'b0, 8'h24 + 8'(k));
         tick();
         if (k >= 1) check($sformatf("simul_rgb%0d", k), 32'(rgb()), 32'({3{8'h20 + 8'(k)}}));
         check($sformatf("simul_level%0d", k), 32'(status[9:0]), 32'd3);
      end
      tick();
      check("simul_rgb_last", 32'(rgb()), 32'h282828);
      check("simul_level_last", 32'(status[9:0]), 32'd3);

      // Reset mid-frame with a non-empty FIFO.
      wait_pos(11, 0);
      check("mid_rst_pre_level", 32'(status[9:0]), 32'd3);
      reset = 1'b1;
      tick();
      check("mid_rst_status", 32'(status), 32'h0);
      check("mid_rst_outs", {7'h0, rgb(), vga_hs, vga_vs, vga_blank_n}, 32'b110);
      reset = 1'b0;
      tick();
      check("mid_rst_origin_blank", 32'(vga_blank_n), 32'h1);
      check("mid_rst_origin_status", 32'(status), 32'h4000);
      push(1'b0, 8'h77);
      repeat (2) tick();
      check("post_rst_push_level", 32'(status[9:0]), 32'h1);
      tick();
      check("post_rst_rgb", 32'(rgb()), 32'h777777);
      check("post_rst_level", 32'(status[9:0]), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
